csr_io_unit: RTL and testbench

Parametrised CSR/GPIO unit for the pipelined RV32I core. It generalises the core's hard-wired switch/HEX CSR mapping to N_IN input and N_OUT output channels, and adds full CSRRW/CSRRS/CSRRC semantics, input synchronisers, a read-only cycle counter and WB-to-EX bypass. It sits beside the regfile:

- EX-stage accesses are sampled on a clock edge.
- Read data is returned registered for the WB-stage writeback mux.
- Output writes commit one cycle later, in WB.

---
 rtl/csr_io_unit.sv | 175 +++++++++++++++++
 tb/tb_csr_io_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_io_unit.sv
// CSR/GPIO unit beside the RV32I regfile: N_IN synchronised input channels, N_OUT
// registered output channels and a free-running cycle counter, with CSRRW/RS/RC semantics.
module csr_io_unit #(
  parameter int          DATA_W      = 32,
  parameter int          N_IN        = 2,
  parameter int          N_OUT       = 2,
  parameter logic [11:0] IN_BASE     = 12'hF00,
  parameter logic [11:0] OUT_BASE    = 12'hF02,
  parameter logic [11:0] CYC_ADDR    = 12'hC00,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_IN*DATA_W-1:0]  gpio_in,
  output logic [N_OUT*DATA_W-1:0] gpio_out,
  input  logic                    ex_valid,
  input  logic [1:0]              ex_op,
  input  logic [11:0]             ex_addr,
  input  logic [DATA_W-1:0]       ex_wdata,
  input  logic                    ex_wsup,
  output logic [DATA_W-1:0]       wb_rdata,
  output logic                    wb_rvalid,
  output logic                    wb_illegal
);

  localparam int IW_IN  = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int IW_OUT = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  // Handshake: there is no ready. An access is accepted on every edge where
  // ex_valid=1 and ex_op!=00; its response is presented on wb_* for exactly the
  // following cycle with wb_rvalid=1, and wb_* return to zero when no access follows.

  logic [N_IN*DATA_W-1:0] r_sync [SYNC_STAGES];
  logic [DATA_W-1:0]      r_out  [N_OUT];
  logic [DATA_W-1:0]      r_cyc;
  logic                   r_pend_valid;
  logic [IW_OUT-1:0]      r_pend_idx;
  logic [DATA_W-1:0]      r_pend_data;
  logic [DATA_W-1:0]      r_rdata;
  logic                   r_rvalid;
  logic                   r_illegal;

  logic [DATA_W-1:0] w_in_ch [N_IN];
  logic [11:0]       w_in_off;
  logic [11:0]       w_out_off;
  logic [IW_IN-1:0]  w_in_idx;
  logic [IW_OUT-1:0] w_out_idx;
  logic              w_is_in;
  logic              w_is_out;
  logic              w_is_cyc;
  logic              w_access;
  logic              w_wr_intent;
  logic              w_illegal;
  logic              w_out_wr;
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_new;

  // Address decode: channel offsets relative to each base, modulo 12 bits.
  assign w_in_off  = ex_addr - IN_BASE;
  assign w_out_off = ex_addr - OUT_BASE;
  assign w_in_idx  = w_in_off[IW_IN-1:0];
  assign w_out_idx = w_out_off[IW_OUT-1:0];
  assign w_is_in   = (w_in_off  < 12'(N_IN));
  assign w_is_out  = !w_is_in && (w_out_off < 12'(N_OUT));
  assign w_is_cyc  = !w_is_in && !w_is_out && (ex_addr == CYC_ADDR);

  assign w_access    = ex_valid && (ex_op != OP_NONE);
  assign w_wr_intent = (ex_op == OP_RW) || !ex_wsup;
  assign w_illegal   = !(w_is_in || w_is_out || w_is_cyc) ||
                       (w_wr_intent && (w_is_in || w_is_cyc));
  assign w_out_wr    = w_access && w_is_out && w_wr_intent;

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      w_in_ch[i] = r_sync[SYNC_STAGES-1][i*DATA_W +: DATA_W];
    end
  end

  // A write still waiting in WB is the architectural value of its channel.
  always_comb begin
    w_old = '0;
    if (w_is_in) begin
      w_old = w_in_ch[w_in_idx];
    end else if (w_is_out) begin
      if (r_pend_valid && (r_pend_idx == w_out_idx)) begin
        w_old = r_pend_data;
      end else begin
        w_old = r_out[w_out_idx];
      end
    end else if (w_is_cyc) begin
      w_old = r_cyc;
    end
  end

  always_comb begin
    w_new = w_old;
    case (ex_op)
      OP_RW:   w_new = ex_wdata;
      OP_RS:   w_new = w_old | ex_wdata;
      OP_RC:   w_new = w_old & ~ex_wdata;
      default: w_new = w_old;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cyc <= '0;
    end else begin
      r_cyc <= r_cyc + DATA_W'(1);
    end
  end

  // WB stage: commit the pending write while capturing the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < N_OUT; j++) begin
        r_out[j] <= '0;
      end
      r_pend_valid <= 1'b0;
      r_pend_idx   <= '0;
      r_pend_data  <= '0;
    end else begin
      if (r_pend_valid) begin
        r_out[r_pend_idx] <= r_pend_data;
      end
      r_pend_valid <= w_out_wr;
      if (w_out_wr) begin
        r_pend_idx  <= w_out_idx;
        r_pend_data <= w_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_rvalid  <= w_access;
      r_illegal <= w_access && w_illegal;
      r_rdata   <= (w_access && !w_illegal) ? w_old : '0;
    end
  end

  always_comb begin
    gpio_out = '0;
    for (int j = 0; j < N_OUT; j++) begin
      gpio_out[j*DATA_W +: DATA_W] = r_out[j];
    end
  end

  assign wb_rdata   = r_rdata;
  assign wb_rvalid  = r_rvalid;
  assign wb_illegal = r_illegal;

endmodule

// File: tb/tb_csr_io_unit.sv
// Bench for csr_io_unit: directed scenarios plus randomized accesses against a
// channel-level reference model; an 8-bit instance covers counter wrap.
module tb_csr_io_unit;

  localparam int S = 2;

  logic        clk;
  logic        rst;
  logic [63:0] gpio_in;
  logic [63:0] gpio_out;
  logic        ex_valid;
  logic [1:0]  ex_op;
  logic [11:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        ex_wsup;
  logic [31:0] wb_rdata;
  logic        wb_rvalid;
  logic        wb_illegal;

  logic [15:0] g8_in;
  logic [15:0] g8_out;
  logic        e8_valid;
  logic [1:0]  e8_op;
  logic [11:0] e8_addr;
  logic [7:0]  e8_wdata;
  logic        e8_wsup;
  logic [7:0]  r8_rdata;
  logic        r8_rvalid;
  logic        r8_illegal;

  int checks;
  int errors;

  // Reference model: latest architectural value per output channel, what gpio_out
  // should show now, input samples of the last S edges, edges since reset release.
  logic [31:0] m_arch [2];
  logic [63:0] m_gpio;
  logic [63:0] in_hist [$];
  logic [31:0] m_cyc;
  logic [31:0] exp_q [$];

  csr_io_unit #(.SYNC_STAGES(S)) u_dut (
    .clk(clk), .rst(rst), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_wsup(ex_wsup), .wb_rdata(wb_rdata), .wb_rvalid(wb_rvalid), .wb_illegal(wb_illegal)
  );

  csr_io_unit #(.DATA_W(8), .SYNC_STAGES(S)) u_dut8 (
    .clk(clk), .rst(rst), .gpio_in(g8_in), .gpio_out(g8_out),
    .ex_valid(e8_valid), .ex_op(e8_op), .ex_addr(e8_addr), .ex_wdata(e8_wdata),
    .ex_wsup(e8_wsup), .wb_rdata(r8_rdata), .wb_rvalid(r8_rvalid), .wb_illegal(r8_illegal)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_arch[0] = '0;
    m_arch[1] = '0;
    m_gpio    = '0;
    m_cyc     = '0;
    in_hist.delete();
    for (int i = 0; i < S; i++) in_hist.push_back('0);
  endtask

  // Drive one EX access (called at a negedge), predict its WB response from the
  // architectural rules, then wait until the following negedge.
  task automatic cycle(input logic v, input logic [1:0] op, input logic [11:0] addr,
                       input logic [31:0] wd, input logic ws,
                       output logic [31:0] e_rdata, output logic e_rvalid,
                       output logic e_ill);
    logic [63:0] vis;
    logic [63:0] next_gpio;
    logic [31:0] old;
    logic        acc;
    logic        wr;
    logic        legal;
    logic        is_out;
    int          ch;
    ex_valid = v; ex_op = op; ex_addr = addr; ex_wdata = wd; ex_wsup = ws;
    vis       = in_hist[0];
    next_gpio = {m_arch[1], m_arch[0]};
    acc       = v && (op != 2'b00);
    wr        = (op == 2'b01) || !ws;
    e_rdata   = '0;
    e_rvalid  = acc;
    e_ill     = 1'b0;
    if (acc) begin
      legal = 1'b1; is_out = 1'b0; old = '0; ch = 0;
      if (addr == 12'hF00 || addr == 12'hF01) begin
        ch = int'(addr - 12'hF00);
        old = vis[ch*32 +: 32];
        if (wr) legal = 1'b0;
      end else if (addr == 12'hF02 || addr == 12'hF03) begin
        ch = int'(addr - 12'hF02);
        old = m_arch[ch];
        is_out = 1'b1;
      end else if (addr == 12'hC00) begin
        old = m_cyc;
        if (wr) legal = 1'b0;
      end else begin
        legal = 1'b0;
      end
      if (legal) begin
        e_rdata = old;
        if (is_out && wr) begin
          case (op)
            2'b01:   m_arch[ch] = wd;
            2'b10:   m_arch[ch] = old | wd;
            default: m_arch[ch] = old & ~wd;
          endcase
        end
      end else begin
        e_ill = 1'b1;
      end
    end
    @(posedge clk);
    m_gpio = next_gpio;
    m_cyc  = m_cyc + 32'd1;
    in_hist.push_back(gpio_in);
    void'(in_hist.pop_front());
    @(negedge clk);
  endtask

  task automatic idle();
    logic [31:0] r; logic v; logic i;
    cycle(1'b0, 2'b00, 12'h000, 32'h0, 1'b0, r, v, i);
  endtask

  task automatic test_reset();
    logic [31:0] er; logic ev; logic ei;
    rst = 1'b0;
    gpio_in = '1;
    ex_valid = 1'b1; ex_op = 2'b01; ex_addr = 12'hF02; ex_wdata = $urandom; ex_wsup = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (gpio_out !== 64'h0) begin errors++; $display("FAIL reset_gpio_out: got %h expected 0", gpio_out); end
    checks++; if (wb_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", wb_rdata); end
    checks++; if (wb_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", wb_rvalid); end
    checks++; if (wb_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", wb_illegal); end
    ex_valid = 1'b0;
    rst = 1'b1;
    gpio_in = '0;
    model_reset();
    for (int n = 0; n < 4; n++) begin
      cycle(1'b1, 2'b10, 12'hC00, 32'h0, 1'b1, er, ev, ei);
      checks++; if (wb_rdata !== 32'(n)) begin errors++; $display("FAIL reset_cyc_read%0d: got %h expected %h", n, wb_rdata, n); end
      checks++; if (wb_rvalid !== 1'b1 || wb_illegal !== 1'b0) begin errors++; $display("FAIL reset_cyc_flags%0d: got v=%b i=%b expected v=1 i=0", n, wb_rvalid, wb_illegal); end
    end
  endtask

  task automatic test_rw_read();
    logic [31:0] er; logic ev; logic ei;
    cycle(1'b1, 2'b01, 12'hF02, 32'h1234, 1'b0, er, ev, ei);
    checks++; if (wb_rdata !== 32'h0 || wb_rvalid !== 1'b1) begin errors++; $display("FAIL rw_old: got %h v=%b expected 0 v=1", wb_rdata, wb_rvalid); end
    checks++; if (gpio_out[31:0] !== 32'h0) begin errors++; $display("FAIL rw_not_yet: got %h expected 0", gpio_out[31:0]); end
    idle();
    checks++; if (gpio_out[31:0] !== 32'h1234) begin errors++; $display("FAIL rw_commit: got %h expected 1234", gpio_out[31:0]); end
    checks++; if (wb_rvalid !== 1'b0 || wb_rdata !== 32'h0) begin errors++; $display("FAIL rw_drop: got %h v=%b expected 0 v=0", wb_rdata, wb_rvalid); end
    cycle(1'b1, 2'b10, 12'hF02, 32'hFFFF_FFFF, 1'b1, er, ev, ei);
    checks++; if (wb_rdata !== 32'h1234) begin errors++; $display("FAIL rs_wsup_read: got %h expected 1234", wb_rdata); end
    idle();
    checks++; if (gpio_out[31:0] !== 32'h1234) begin errors++; $display("FAIL rs_wsup_nochange: got %h expected 1234", gpio_out[31:0]); end
  endtask

  task automatic test_bypass();
    logic [31:0] er; logic ev; logic ei;
    cycle(1'b1, 2'b01, 12'hF03, 32'hFF00, 1'b0, er, ev, ei);
    cycle(1'b1, 2'b10, 12'hF03, 32'h000F, 1'b0, er, ev, ei);
    checks++; if (wb_rdata !== 32'hFF00) begin errors++; $display("FAIL bypass_old: got %h expected ff00", wb_rdata); end
    checks++; if (gpio_out[63:32] !== 32'hFF00) begin errors++; $display("FAIL bypass_first: got %h expected ff00", gpio_out[63:32]); end
    idle();
    checks++; if (gpio_out[63:32] !== 32'hFF0F) begin errors++; $display("FAIL bypass_second: got %h expected ff0f", gpio_out[63:32]); end
  endtask

  task automatic test_clear_illegal();
    logic [31:0] er; logic ev; logic ei;
    cycle(1'b1, 2'b11, 12'hF02, 32'h0004, 1'b0, er, ev, ei);
    checks++; if (wb_rdata !== 32'h1234) begin errors++; $display("FAIL rc_old: got %h expected 1234", wb_rdata); end
    idle();
    checks++; if (gpio_out[31:0] !== 32'h1230) begin errors++; $display("FAIL rc_new: got %h expected 1230", gpio_out[31:0]); end
    cycle(1'b1, 2'b01, 12'hF00, 32'hDEAD, 1'b0, er, ev, ei);
    checks++; if (wb_illegal !== 1'b1 || wb_rdata !== 32'h0 || wb_rvalid !== 1'b1) begin errors++; $display("FAIL ill_in_write: got i=%b d=%h v=%b expected i=1 d=0 v=1", wb_illegal, wb_rdata, wb_rvalid); end
    cycle(1'b1, 2'b01, 12'hC00, 32'h5, 1'b0, er, ev, ei);
    checks++; if (wb_illegal !== 1'b1 || wb_rdata !== 32'h0) begin errors++; $display("FAIL ill_cyc_write: got i=%b d=%h expected i=1 d=0", wb_illegal, wb_rdata); end
    cycle(1'b1, 2'b10, 12'h123, 32'h0, 1'b1, er, ev, ei);
    checks++; if (wb_illegal !== 1'b1 || wb_rdata !== 32'h0) begin errors++; $display("FAIL ill_unmapped: got i=%b d=%h expected i=1 d=0", wb_illegal, wb_rdata); end
    checks++; if (gpio_out !== {32'hFF0F, 32'h1230}) begin errors++; $display("FAIL ill_nochange: got %h expected %h", gpio_out, {32'hFF0F, 32'h1230}); end
  endtask

  task automatic test_diff_channel();
    logic [31:0] er; logic ev; logic ei;
    logic [31:0] a; logic [31:0] b;
    a = $urandom; b = $urandom;
    cycle(1'b1, 2'b01, 12'hF02, a, 1'b0, er, ev, ei);
    cycle(1'b1, 2'b01, 12'hF03, b, 1'b0, er, ev, ei);
    checks++; if (wb_rdata !== 32'hFF0F) begin errors++; $display("FAIL diff_old: got %h expected ff0f", wb_rdata); end
    checks++; if (gpio_out !== {32'hFF0F, a}) begin errors++; $display("FAIL diff_first: got %h expected %h", gpio_out, {32'hFF0F, a}); end
    idle();
    checks++; if (gpio_out !== {b, a}) begin errors++; $display("FAIL diff_second: got %h expected %h", gpio_out, {b, a}); end
  endtask

  task automatic test_input_sync();
    logic [31:0] er; logic ev; logic ei;
    gpio_in = '0;
    repeat (S + 1) idle();
    gpio_in[63:32] = 32'hA5;
    for (int t = 0; t <= S; t++) begin
      cycle(1'b1, 2'b10, 12'hF01, 32'h0, 1'b1, er, ev, ei);
      checks++;
      if (wb_rdata !== ((t < S) ? 32'h0 : 32'hA5)) begin
        errors++; $display("FAIL sync_t%0d: got %h expected %h", t, wb_rdata, (t < S) ? 32'h0 : 32'hA5);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] er; logic ev; logic ei;
    logic [11:0] a;
    logic [31:0] exp_d;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) gpio_in = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: a = 12'hF00;
        1: a = 12'hF01;
        2: a = 12'hF02;
        3: a = 12'hF03;
        4: a = 12'hC00;
        default: a = 12'($urandom);
      endcase
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom), a, $urandom,
            1'($urandom_range(0, 1)), er, ev, ei);
      exp_q.push_back(er);
      exp_d = exp_q.pop_front();
      checks++;
      if (wb_rdata !== exp_d || wb_rvalid !== ev || wb_illegal !== ei) begin
        errors++;
        $display("FAIL rand_resp%0d: got d=%h v=%b i=%b expected d=%h v=%b i=%b",
                 n, wb_rdata, wb_rvalid, wb_illegal, exp_d, ev, ei);
      end
      checks++;
      if (gpio_out !== m_gpio) begin
        errors++; $display("FAIL rand_gpio%0d: got %h expected %h", n, gpio_out, m_gpio);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] er; logic ev; logic ei;
    int guard;
    guard = 0;
    while (m_cyc[7:0] != 8'hFF && guard < 300) begin
      idle();
      guard++;
    end
    checks++;
    if (m_cyc[7:0] != 8'hFF) begin errors++; $display("FAIL wrap_reach: got %h expected ff", m_cyc[7:0]); end
    e8_valid = 1'b1; e8_op = 2'b10; e8_addr = 12'hC00; e8_wsup = 1'b1;
    idle();
    checks++; if (r8_rdata !== 8'hFF || r8_rvalid !== 1'b1) begin errors++; $display("FAIL wrap_ff: got %h v=%b expected ff v=1", r8_rdata, r8_rvalid); end
    idle();
    checks++; if (r8_rdata !== 8'h00 || r8_illegal !== 1'b0) begin errors++; $display("FAIL wrap_00: got %h i=%b expected 00 i=0", r8_rdata, r8_illegal); end
    e8_valid = 1'b0;
    cycle(1'b1, 2'b10, 12'hC00, 32'h0, 1'b1, er, ev, ei);
    checks++; if (wb_rdata !== er) begin errors++; $display("FAIL wrap_cyc32: got %h expected %h", wb_rdata, er); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] er; logic ev; logic ei;
    cycle(1'b1, 2'b01, 12'hF02, 32'hBEEF, 1'b0, er, ev, ei);
    ex_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (gpio_out !== 64'h0 || wb_rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_async: got %h v=%b expected 0 v=0", gpio_out, wb_rvalid); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (gpio_out !== 64'h0) begin errors++; $display("FAIL rstmid_hold: got %h expected 0", gpio_out); end
    rst = 1'b1;
    model_reset();
    idle();
    idle();
    checks++; if (gpio_out !== 64'h0) begin errors++; $display("FAIL rstmid_after: got %h expected 0", gpio_out); end
    cycle(1'b1, 2'b10, 12'hF02, 32'h0, 1'b1, er, ev, ei);
    checks++; if (wb_rdata !== 32'h0 || wb_rvalid !== 1'b1) begin errors++; $display("FAIL rstmid_read: got %h v=%b expected 0 v=1", wb_rdata, wb_rvalid); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0;
    gpio_in = '0; ex_valid = 1'b0; ex_op = 2'b00; ex_addr = '0; ex_wdata = '0; ex_wsup = 1'b0;
    g8_in = '0; e8_valid = 1'b0; e8_op = 2'b00; e8_addr = '0; e8_wdata = '0; e8_wsup = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_rw_read();
    test_bypass();
    test_clear_illegal();
    test_diff_channel();
    test_input_sync();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
